// File: rtl/sdrd_pkg.sv
// Shared definitions for the SDRD serial frame capture path.
//   - sdrd_state_e : capture FSM states
//   - QUAL_BA13/12 : address bits that select the serial data port
//   - DEFAULT_SYNC_BYTE : frame start marker, received MSB first
//   - sdrd_port_sel() : decodes a port selection from sser_n/ba13/ba12
package sdrd_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } sdrd_state_e;

    localparam logic QUAL_BA13 = 1'b0;
    localparam logic QUAL_BA12 = 1'b1;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // True when the access targets the serial data port (read or write).
    function automatic logic sdrd_port_sel(input logic sser_n, input logic ba13,
                                           input logic ba12);
        return ~sser_n & (ba13 == QUAL_BA13) & (ba12 == QUAL_BA12);
    endfunction

endpackage

// File: rtl/sdrd_byte_fifo.sv
// Byte FIFO with a push/full write side and a valid/ready read side.
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push        : write request for push_data
//   push_data   : byte to store
//   full        : all DEPTH entries occupied
//   push_drop   : push refused this cycle (full with no simultaneous pop)
//   out_valid   : FIFO non-empty
//   out_data    : head entry
//   out_ready   : consumer takes the head when out_valid=1
module sdrd_byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    output logic       full,
    output logic       push_drop,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic [7:0]   mem_q [DEPTH];
    logic         empty;
    logic         pop;
    logic         push_ok;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign out_valid = ~empty;
    assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot the push lands in.
    assign push_ok   = push & (~full | pop);
    assign push_drop = push & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdrd_frame_capture.sv
// Samples SDRD on each qualified serial-port read, hunts for SYNC_BYTE with a
// sliding 8-bit window, then assembles FRAME_BYTES MSB-first payload bytes into
// an output FIFO.
//   clk, rst_n        : clock, asynchronous active-low reset
//   sser_n, ba13,
//   ba12, br_w        : bus access qualifiers (br_w=1 is a read)
//   acc_stb           : one-cycle sampling point of a bus access
//   sdrd              : serial data bit, valid with acc_stb
//   clr               : clear overflow and force HUNT
//   out_valid/out_data/out_ready : byte stream to the host side
//   locked            : frame capture in progress
//   frame_done        : pulse with the last payload byte of a frame
//   overflow          : sticky, a byte was dropped on a full FIFO
module sdrd_frame_capture
    import sdrd_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
    parameter int unsigned FRAME_BYTES = 4,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sser_n,
    input  logic       ba13,
    input  logic       ba12,
    input  logic       br_w,
    input  logic       acc_stb,
    input  logic       sdrd,
    input  logic       clr,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       locked,
    output logic       frame_done,
    output logic       overflow
);

    localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);

    sdrd_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic        overflow_q, overflow_d;
    logic        frame_done_q, frame_done_d;

    logic        rd_q, wr_q;
    logic [7:0]  shifted;
    logic        push;
    logic        push_drop;
    logic        fifo_full;

    assign rd_q    = acc_stb & sdrd_port_sel(sser_n, ba13, ba12) &  br_w;
    assign wr_q    = acc_stb & sdrd_port_sel(sser_n, ba13, ba12) & ~br_w;
    assign shifted = {shift_q[6:0], sdrd};

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        frame_done_d = 1'b0;
        push         = 1'b0;

        if (clr || wr_q) begin
            // Resync: any partial byte is discarded, nothing is pushed.
            state_d    = HUNT;
            shift_d    = 8'h00;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
        end else if (rd_q) begin
            shift_d = shifted;
            unique case (state_q)
                HUNT: begin
                    if (shifted == SYNC_BYTE) begin
                        state_d    = LOCKED;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        push = 1'b1;
                        if (byte_cnt_q == LAST_BYTE) begin
                            frame_done_d = 1'b1;
                            state_d      = HUNT;
                            shift_d      = 8'h00;
                            byte_cnt_d   = '0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // clr takes priority over a drop in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (clr) begin
            overflow_d = 1'b0;
        end else if (push_drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            shift_q      <= 8'h00;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    sdrd_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (shifted),
        .full      (fifo_full),
        .push_drop (push_drop),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    assign locked     = (state_q == LOCKED);
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule
